// File: rtl/eeprom_i2c_slave.sv
// Two-wire serial EEPROM responder: oversamples SCL/SDA on CLK, decodes the byte
// protocol and serves byte/sequential writes and current/random/sequential reads.
module eeprom_i2c_slave #(
    parameter int         ADDR_W   = 11,
    parameter logic [3:0] DEV_CODE = 4'b1010
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
    output logic BUSY,
    output logic WR_DONE
);

    localparam int MEM_D = 1 << ADDR_W;
    localparam int HI_W  = ADDR_W - 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTRL,
        ST_ACK_CTRL,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_t;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;

    state_t              state_q, state_n;
    logic [2:0]          bit_cnt_q, bit_cnt_n;
    logic [7:0]          shreg_q, shreg_n;
    logic [7:0]          tx_q, tx_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                rw_q, rw_n;
    logic                sda_oe_q, sda_oe_n;
    logic                ack_ph_q, ack_ph_n;
    logic                wr_done_q, wr_done_n;
    logic                wr_en;

    logic [7:0] mem [MEM_D];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;

    // Stage p0/p1: two-flop synchroniser; p2: previous synced value for edge detection
    always_ff @(posedge CLK) begin
        scl_p0 <= SCL;
        scl_p1 <= scl_p0;
        scl_p2 <= scl_p1;
        sda_p0 <= SDA;
        sda_p1 <= sda_p0;
        sda_p2 <= sda_p1;
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
    assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;
    assign rx_byte   = {shreg_q[6:0], sda_p1};
    assign rd_byte   = mem[addr_q];

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shreg_n   = shreg_q;
        tx_n      = tx_q;
        addr_n    = addr_q;
        rw_n      = rw_q;
        sda_oe_n  = sda_oe_q;
        ack_ph_n  = ack_ph_q;
        wr_done_n = 1'b0;
        wr_en     = 1'b0;

        if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
            ack_ph_n = 1'b0;
        end else if (start_det) begin
            state_n   = ST_CTRL;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            ack_ph_n  = 1'b0;
        end else begin
            case (state_q)
                ST_CTRL, ST_ADDR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_ph_n = 1'b0;
                            if (state_q == ST_CTRL) begin
                                if (rx_byte[7:4] != DEV_CODE) begin
                                    state_n = ST_IGNORE;
                                end else begin
                                    addr_n[ADDR_W-1:8] = rx_byte[HI_W:1];
                                    rw_n               = rx_byte[0];
                                    state_n            = ST_ACK_CTRL;
                                end
                            end else if (state_q == ST_ADDR) begin
                                addr_n[7:0] = rx_byte;
                                state_n     = ST_ACK_ADDR;
                            end else begin
                                wr_en     = 1'b1;
                                wr_done_n = 1'b1;
                                addr_n    = addr_q + ADDR_W'(1);
                                state_n   = ST_ACK_WDATA;
                            end
                        end
                    end
                end
                ST_ACK_CTRL, ST_ACK_ADDR, ST_ACK_WDATA: begin
                    // First falling edge starts the ACK, second one ends the 9th period
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_oe_n = 1'b1;
                            ack_ph_n = 1'b1;
                        end else begin
                            ack_ph_n  = 1'b0;
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd0;
                            if (state_q == ST_ACK_CTRL && rw_q) begin
                                state_n  = ST_RDATA;
                                sda_oe_n = ~rd_byte[7];
                                tx_n     = {rd_byte[6:0], 1'b0};
                            end else if (state_q == ST_ACK_CTRL) begin
                                state_n = ST_ADDR;
                            end else begin
                                state_n = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        sda_oe_n = ~tx_q[7];
                        tx_n     = {tx_q[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_n  = addr_q + ADDR_W'(1);
                            state_n = ST_RACK;
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                    end else if (scl_rise) begin
                        if (!sda_p1) begin
                            state_n   = ST_RDATA;
                            tx_n      = rd_byte;
                            bit_cnt_n = 3'd0;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            ack_ph_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            addr_q    <= addr_n;
            rw_q      <= rw_n;
            sda_oe_q  <= sda_oe_n;
            ack_ph_q  <= ack_ph_n;
            wr_done_q <= wr_done_n;
        end
    end

    always_ff @(posedge CLK) begin
        shreg_q <= shreg_n;
        tx_q    <= tx_n;
        if (wr_en) begin
            mem[addr_q] <= rx_byte;
        end
    end

    assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
    assign BUSY    = (state_q != ST_IDLE) && !stop_det && !RESET;
    assign WR_DONE = wr_done_q;

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Bench for eeprom_i2c_slave: bus-level master tasks plus an array/address-counter
// reference model of the EEPROM, with randomized write/read traffic.
module tb_eeprom_i2c_slave;

    localparam int Q     = 6;
    localparam int MEMSZ = 2048;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic SCL = 1'b1;
    logic tb_sda = 1'b1;
    wire  SDA;
    logic BUSY, WR_DONE;

    pullup (SDA);
    assign SDA = tb_sda ? 1'bz : 1'b0;

    eeprom_i2c_slave #(.ADDR_W(11), .DEV_CODE(4'b1010)) dut (
        .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA(SDA), .BUSY(BUSY), .WR_DONE(WR_DONE)
    );

    always #5 CLK = ~CLK;

    int tests_run = 0;
    int tests_failed = 0;
    int wr_pulses = 0;
    int pulled_cnt = 0;

    always @(negedge CLK) begin
        if (WR_DONE === 1'b1) wr_pulses <= wr_pulses + 1;
        if (tb_sda && SDA !== 1'b1) pulled_cnt <= pulled_cnt + 1;
    end

    logic [7:0] ref_mem [MEMSZ];
    int         ref_addr;
    logic [7:0] wq[$];
    logic [7:0] rq[$];

    task automatic wait_q();
        repeat (Q) @(negedge CLK);
    endtask

    task automatic bus_start();
        tb_sda = 1'b1; wait_q();
        SCL = 1'b1;    wait_q();
        tb_sda = 1'b0; wait_q();
        SCL = 1'b0;    wait_q();
    endtask

    task automatic bus_stop();
        tb_sda = 1'b0; wait_q();
        SCL = 1'b1;    wait_q();
        tb_sda = 1'b1; wait_q();
    endtask

    task automatic bus_bit(input logic b, output logic s);
        tb_sda = b; wait_q();
        SCL = 1'b1; wait_q();
        s = SDA;    wait_q();
        SCL = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = (s === 1'b0);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(nack, s);
    endtask

    task automatic send_hdr(input int a, output int acks);
        logic [10:0] aa;
        logic k;
        aa = a[10:0];
        acks = 0;
        bus_start();
        send_byte({4'b1010, aa[10:8], 1'b0}, k); acks += int'(k);
        send_byte(aa[7:0], k);                   acks += int'(k);
    endtask

    task automatic xfer_write(input int a, output int acks);
        logic k;
        send_hdr(a, acks);
        foreach (wq[i]) begin
            send_byte(wq[i], k);
            acks += int'(k);
        end
        bus_stop();
    endtask

    task automatic read_tail(input int hi, input int n, inout int acks);
        logic [2:0] h;
        logic [7:0] d;
        logic k;
        h = hi[2:0];
        send_byte({4'b1010, h, 1'b1}, k); acks += int'(k);
        rq.delete();
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, d);
            rq.push_back(d);
        end
        bus_stop();
    endtask

    task automatic xfer_rand_read(input int a, input int n, output int acks);
        send_hdr(a, acks);
        bus_start();
        read_tail(a / 256, n, acks);
    endtask

    task automatic xfer_cur_read(input int hi, input int n, output int acks);
        acks = 0;
        bus_start();
        read_tail(hi, n, acks);
    endtask

    // Reference model: an EEPROM is an array plus a wrapping address counter.
    task automatic model_write(input int a);
        foreach (wq[i]) ref_mem[(a + i) % MEMSZ] = wq[i];
        ref_addr = (a + wq.size()) % MEMSZ;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        ref_addr = 0;
        @(negedge CLK);
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        tests_run++; if (WR_DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_done got=%b exp=0", WR_DONE); end
        tests_run++; if (SDA !== 1'b1) begin tests_failed++; $display("FAIL reset_sda got=%b exp=1", SDA); end
    endtask

    task automatic test_byte_write();
        int acks, w0;
        wq = '{8'hA5};
        w0 = wr_pulses;
        xfer_write(32'h123, acks);
        model_write(32'h123);
        repeat (4) @(negedge CLK);
        tests_run++; if (acks !== 3) begin tests_failed++; $display("FAIL bw_acks got=%0d exp=3", acks); end
        tests_run++; if (wr_pulses - w0 !== 1) begin tests_failed++; $display("FAIL bw_wr_done got=%0d exp=1", wr_pulses - w0); end
    endtask

    task automatic test_random_read();
        int acks, exp_a;
        wq = '{8'h5A};
        xfer_write(32'h124, acks);
        model_write(32'h124);
        xfer_rand_read(32'h123, 1, acks);
        tests_run++; if (acks !== 3) begin tests_failed++; $display("FAIL rr_acks got=%0d exp=3", acks); end
        tests_run++; if (rq[0] !== 8'hA5) begin tests_failed++; $display("FAIL rr_data got=%h exp=a5", rq[0]); end
        ref_addr = 32'h124;
        exp_a = 256 + ref_addr % 256;
        xfer_cur_read(1, 1, acks);
        tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL cr_acks got=%0d exp=1", acks); end
        tests_run++; if (rq[0] !== ref_mem[exp_a]) begin tests_failed++; $display("FAIL cr_data got=%h exp=%h", rq[0], ref_mem[exp_a]); end
        ref_addr = (exp_a + 1) % MEMSZ;
    endtask

    task automatic test_seq_wrap();
        int acks, w0;
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        w0 = wr_pulses;
        xfer_write(32'h7FE, acks);
        model_write(32'h7FE);
        repeat (4) @(negedge CLK);
        tests_run++; if (acks !== 6) begin tests_failed++; $display("FAIL sw_acks got=%0d exp=6", acks); end
        tests_run++; if (wr_pulses - w0 !== 4) begin tests_failed++; $display("FAIL sw_wr_done got=%0d exp=4", wr_pulses - w0); end
        xfer_rand_read(32'h7FE, 4, acks);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (rq[i] !== ref_mem[(32'h7FE + i) % MEMSZ]) begin
                tests_failed++; $display("FAIL sw_read%0d got=%h exp=%h", i, rq[i], ref_mem[(32'h7FE + i) % MEMSZ]);
            end
        end
        send_hdr(32'h7FE, acks);
        bus_stop();
        ref_addr = 32'h7FE;
        xfer_cur_read(7, 1, acks);
        tests_run++; if (rq[0] !== ref_mem[32'h7FE]) begin tests_failed++; $display("FAIL sw_cur got=%h exp=%h", rq[0], ref_mem[32'h7FE]); end
        ref_addr = 32'h7FF;
    endtask

    task automatic test_bad_code();
        int p0, w0, acks;
        logic k;
        p0 = pulled_cnt;
        w0 = wr_pulses;
        bus_start();
        tests_run++; if (BUSY !== 1'b1) begin tests_failed++; $display("FAIL bc_busy_in got=%b exp=1", BUSY); end
        send_byte(8'h52, k);
        tests_run++; if (k !== 1'b0) begin tests_failed++; $display("FAIL bc_ack got=%b exp=0", k); end
        send_byte(8'h23, k);
        send_byte(8'h99, k);
        bus_stop();
        repeat (4) @(negedge CLK);
        tests_run++; if (pulled_cnt !== p0) begin tests_failed++; $display("FAIL bc_sda_driven got=%0d exp=%0d", pulled_cnt, p0); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL bc_busy got=%b exp=0", BUSY); end
        tests_run++; if (wr_pulses !== w0) begin tests_failed++; $display("FAIL bc_wr_done got=%0d exp=%0d", wr_pulses, w0); end
        xfer_rand_read(32'h123, 1, acks);
        tests_run++; if (rq[0] !== ref_mem[32'h123]) begin tests_failed++; $display("FAIL bc_mem got=%h exp=%h", rq[0], ref_mem[32'h123]); end
        ref_addr = 32'h124;
    endtask

    task automatic test_stop_mid();
        int w0, acks;
        logic s;
        w0 = wr_pulses;
        send_hdr(32'h123, acks);
        for (int i = 0; i < 5; i++) bus_bit(1'b0, s);
        bus_stop();
        repeat (4) @(negedge CLK);
        tests_run++; if (wr_pulses !== w0) begin tests_failed++; $display("FAIL sm_wr_done got=%0d exp=%0d", wr_pulses, w0); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL sm_busy got=%b exp=0", BUSY); end
        xfer_rand_read(32'h123, 1, acks);
        tests_run++; if (rq[0] !== ref_mem[32'h123]) begin tests_failed++; $display("FAIL sm_mem got=%h exp=%h", rq[0], ref_mem[32'h123]); end
        ref_addr = 32'h124;
    endtask

    task automatic test_reset_mid_read();
        int acks;
        logic k;
        wq = '{8'h00};
        xfer_write(32'h300, acks);
        model_write(32'h300);
        send_hdr(32'h300, acks);
        bus_start();
        send_byte(8'hA7, k);
        tests_run++; if (SDA !== 1'b0) begin tests_failed++; $display("FAIL rm_sda_pre got=%b exp=0", SDA); end
        RESET = 1'b1;
        @(negedge CLK);
        tests_run++; if (SDA !== 1'b1) begin tests_failed++; $display("FAIL rm_sda got=%b exp=1", SDA); end
        tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL rm_busy got=%b exp=0", BUSY); end
        RESET = 1'b0;
        ref_addr = 0;
        bus_stop();
        xfer_cur_read(3, 1, acks);
        tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL rm_cur_ack got=%0d exp=1", acks); end
        tests_run++; if (rq[0] !== ref_mem[3 * 256 + ref_addr % 256]) begin
            tests_failed++; $display("FAIL rm_cur_data got=%h exp=%h", rq[0], ref_mem[3 * 256 + ref_addr % 256]);
        end
        ref_addr = 3 * 256 + 1;
    endtask

    task automatic test_random();
        int a, n, acks, w0;
        for (int it = 0; it < 6; it++) begin
            a = $urandom_range(0, MEMSZ - 1);
            n = $urandom_range(1, 4);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            w0 = wr_pulses;
            xfer_write(a, acks);
            model_write(a);
            repeat (4) @(negedge CLK);
            tests_run++; if (acks !== n + 2) begin tests_failed++; $display("FAIL rnd_wacks a=%h got=%0d exp=%0d", a, acks, n + 2); end
            tests_run++; if (wr_pulses - w0 !== n) begin tests_failed++; $display("FAIL rnd_wr_done got=%0d exp=%0d", wr_pulses - w0, n); end
            xfer_rand_read(a, n, acks);
            for (int i = 0; i < n; i++) begin
                tests_run++;
                if (rq[i] !== ref_mem[(a + i) % MEMSZ]) begin
                    tests_failed++; $display("FAIL rnd_read a=%h i=%0d got=%h exp=%h", a, i, rq[i], ref_mem[(a + i) % MEMSZ]);
                end
            end
            ref_addr = (a + n) % MEMSZ;
        end
    endtask

    task automatic test_back_to_back();
        int a, acks, ca;
        a = $urandom_range(0, MEMSZ - 1);
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(8'($urandom));
        xfer_write(a, acks);
        model_write(a);
        xfer_rand_read(a, 3, acks);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rq[i] !== ref_mem[(a + i) % MEMSZ]) begin
                tests_failed++; $display("FAIL b2b_rand i=%0d got=%h exp=%h", i, rq[i], ref_mem[(a + i) % MEMSZ]);
            end
        end
        ref_addr = (a + 3) % MEMSZ;
        ca = ref_addr;
        xfer_cur_read(ca / 256, 3, acks);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rq[i] !== ref_mem[(ca + i) % MEMSZ]) begin
                tests_failed++; $display("FAIL b2b_cur i=%0d got=%h exp=%h", i, rq[i], ref_mem[(ca + i) % MEMSZ]);
            end
        end
        ref_addr = (ca + 3) % MEMSZ;
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_random_read();
        test_seq_wrap();
        test_bad_code();
        test_stop_mid();
        test_reset_mid_read();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached, tests_run=%0d", tests_run);
        $fatal(1);
    end

endmodule
